player_uart_tx: RTL
===================

Name: player_uart_tx

Overview:
- Downstream stage of the player input encoder. Consumes the 8-bit encoded player word {rst, 1'b0, projectile[1:0], lane[3:0]} and transmits it over a UART TX line as 8N1 frames.
- Sends a frame whenever the word differs from the last word transmitted.
- Re-sends periodically as a heartbeat, so the game-side receiver resynchronises after dropped bytes.
- Sits inside the UART controller, between the player encoder and the board TX pin.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud); minimum 2.
- HEARTBEAT_CYCLES, 10_000_000, cycles between forced re-sends measured from the last frame start; 0 disables heartbeat.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  encoded player word; may change on any cycle.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a frame is in progress (START..STOP).
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.
- sent_data  output  8  word carried by the most recent frame started.

Behaviour:
- Reset (rst high at a clk edge):
  - tx=1, busy=0, frame_done=0, sent_data=8'h00.
  - State=IDLE; baud, bit and heartbeat counters cleared; force_send=1.
  - Reset mid-frame aborts the frame immediately: tx returns high on the next edge, and no frame_done is asserted.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - A trigger is (data_in != sent_data) OR force_send OR (HEARTBEAT_CYCLES!=0 AND hb_cnt == HEARTBEAT_CYCLES-1).
  - On a trigger at edge N: latch data_in into the shift register and sent_data, clear force_send, clear hb_cnt, go to START.
  - At N+1: tx=0 and busy=1.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - tx = shift[idx], LSB first. Each bit lasts CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle, then IDLE.
  - A new frame may start on the IDLE cycle immediately following, so the minimum gap is 1 cycle of idle-high.
- Frame length: exactly 10*CLKS_PER_BIT cycles with busy=1.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets at each bit boundary.
  - Width is $clog2(CLKS_PER_BIT); there is no drift across bits.
- Heartbeat counter:
  - Free-running in every state and saturates at HEARTBEAT_CYCLES-1.
  - Cleared only on a frame start or reset.
  - If heartbeat expiry occurs while busy, the send is deferred to the first IDLE cycle.
- data_in changes while busy:
  - The in-flight frame is unaffected because it uses the latched word.
  - Only the value present at the next IDLE cycle is compared.
  - Intermediate values, including a change that reverts to sent_data, are never transmitted.
- Simultaneous change and heartbeat expiry produce a single frame.
- After reset, the first IDLE cycle always sends. This holds even when data_in == 8'h00.
- tx is a registered output with no combinational path from data_in.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1.
  - Field-position constants for the player word (RST_BIT=7, FIRE_BIT=5, PROJ_BIT=4, LANE_MSB=3, LANE_LSB=0), shared with the encoder and the receiver.
- Sub-module uart_tx_serializer:
  - Contains the START/DATA/STOP shifter and the baud counter.
  - Interface: clk, rst, start, data[7:0], tx, busy, done; parameter CLKS_PER_BIT.
- player_uart_tx keeps change detection, heartbeat, force_send and sent_data.

Test Plan (CLKS_PER_BIT=4, HEARTBEAT_CYCLES=200):
- Post-reset send: rst high 3 cycles, data_in=8'h00 -> frame starts 1 cycle after rst falls; tx sequence 0,0000_0000,1 at 4 cycles/bit; busy high exactly 40 cycles; frame_done one pulse; sent_data=8'h00.
- Change detect: data_in 8'h03->8'h04 in IDLE -> tx=0 on next cycle; LSB-first bits 0,0,1,0,0,0,0,0; sent_data=8'h04; no further frame while data_in is held, until the heartbeat.
- Change during frame: data_in 8'h24 mid-frame then 8'h25 before STOP ends -> current frame still carries the old word; exactly one following frame carries 8'h25; 8'h24 never appears on tx.
- Heartbeat: data_in held at 8'h13 -> re-sent frames start exactly 200 cycles apart; HEARTBEAT_CYCLES=0 build -> no re-send over 2000 cycles.
- Reset mid-frame: rst asserted during DATA bit 3 -> next edge tx=1, busy=0, no frame_done; after release, a full fresh frame of the current data_in is sent.
- Back-to-back: data_in toggles 8'hA5/8'h5A every 50 cycles -> each frame 40 cycles; stop bit high for 4 cycles then START begins within 1 cycle; a UART checker model decodes every frame with no framing errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants, FSM encodings and player-word field positions.
// Imported by the player encoder, this transmitter and the game-side receiver.
package uart_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t IDLE  = 2'd0;
  localparam uart_state_t START = 2'd1;
  localparam uart_state_t DATA  = 2'd2;
  localparam uart_state_t STOP  = 2'd3;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  // Player word layout: {rst, 1'b0, projectile[1:0], lane[3:0]}
  localparam int unsigned RST_BIT  = 7;
  localparam int unsigned FIRE_BIT = 5;
  localparam int unsigned PROJ_BIT = 4;
  localparam int unsigned LANE_MSB = 3;
  localparam int unsigned LANE_LSB = 0;

  typedef logic [UART_DATA_BITS-1:0] uart_word_t;

  function automatic logic word_changed(input uart_word_t cur, input uart_word_t last);
    return cur != last;
  endfunction

endpackage

// File: rtl/player_uart_tx_if.sv
// Bundle between the player encoder (master) and the UART transmitter (slave).
interface player_uart_tx_if;
  import uart_pkg::*;

  uart_word_t data_in;
  logic       tx;
  logic       busy;
  logic       frame_done;
  uart_word_t sent_data;

  modport master (
    output data_in,
    input  tx,
    input  busy,
    input  frame_done,
    input  sent_data
  );

  modport slave (
    input  data_in,
    output tx,
    output busy,
    output frame_done,
    output sent_data
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: START/DATA/STOP shifter with a per-bit baud counter.
// tx is registered; busy and done decode directly from state registers.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  uart_word_t data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam int unsigned IdxW     = $clog2(UART_DATA_BITS);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(UART_DATA_BITS - 1);

  uart_state_t       state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  uart_word_t        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d   = UART_IDLE_LEVEL;
        baud_d = '0;
        if (start) begin
          shift_d = data;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (idx_q == IdxLast) begin
            tx_d    = UART_IDLE_LEVEL;
            state_d = STOP;
          end else begin
            // Shift right so the next LSB-first bit is always at shift_q[1].
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = UART_IDLE_LEVEL;
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == STOP) && bit_end;

endmodule

// File: rtl/player_uart_tx.sv
// Player-word UART transmitter: sends on change, after reset, and on heartbeat expiry.
// Change detection compares against the last word actually started, not data history.
module player_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT     = 10417,
  parameter int unsigned HEARTBEAT_CYCLES = 10_000_000
) (
  input logic             clk,
  input logic             rst,
  player_uart_tx_if.slave bus
);

  localparam bit          HbEn   = (HEARTBEAT_CYCLES != 0);
  localparam int unsigned HbW    = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [HbW-1:0] HbLast =
    HbW'((HEARTBEAT_CYCLES == 0) ? 0 : HEARTBEAT_CYCLES - 1);

  uart_word_t      sent_q, sent_d;
  logic            force_q, force_d;
  logic [HbW-1:0]  hb_q, hb_d;
  logic            hb_expired;
  logic            start;
  logic            ser_tx, ser_busy, ser_done;

  assign hb_expired = HbEn && (hb_q == HbLast);

  // Triggers are only honoured when idle; a saturated heartbeat waits out the frame.
  assign start = !ser_busy &&
                 (word_changed(bus.data_in, sent_q) || force_q || hb_expired);

  always_comb begin
    sent_d  = sent_q;
    force_d = force_q;
    hb_d    = hb_q;
    if (start) begin
      sent_d  = bus.data_in;
      force_d = 1'b0;
      hb_d    = '0;
    end else if (HbEn && !hb_expired) begin
      hb_d = hb_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q  <= '0;
      force_q <= 1'b1;
      hb_q    <= '0;
    end else begin
      sent_q  <= sent_d;
      force_q <= force_d;
      hb_q    <= hb_d;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_serializer (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .data  (bus.data_in),
    .tx    (ser_tx),
    .busy  (ser_busy),
    .done  (ser_done)
  );

  assign bus.tx         = ser_tx;
  assign bus.busy       = ser_busy;
  assign bus.frame_done = ser_done;
  assign bus.sent_data  = sent_q;

endmodule
